display_scanner: RTL and testbench

Time-multiplexing scan controller for the 4-digit seven-segment display. Sits directly upstream of the anode decoder: it generates the 2-bit digit select that the anode decoder turns into active-low anode enables, and in lockstep presents the 4-bit nibble, decimal point and blank flag for that digit to the segment decoder. New display values are double-buffered and swapped in only at a frame boundary, so a digit never shows a mix of old and new data.

---
 rtl/display_scanner.sv | 121 ++++++++++++
 tb/tb_display_scanner.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexing scan controller for a 4-digit seven-segment display.
//   A prescaler divides clk down to one digit step every DIV enabled cycles.
//   digit_sel walks 0..3 and feeds the anode decoder. nibble, dp and blank
//   describe the selected digit to the segment decoder. New values are held
//   in a pending stage and are copied into the displayed stage only at a
//   frame boundary, or at once while scanning is disabled. This keeps a
//   frame from showing a mix of old and new data.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   en           scan enable; when 0 the prescaler and digit_sel hold
//   data_in      four nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        decimal point per digit, bit i = digit i
//   load         single-cycle request to capture data_in / dp_in
//   blank_lz     leading-zero blanking enable
//   digit_sel    current digit, drives the anode decoder
//   nibble       displayed nibble for digit_sel
//   dp           displayed decimal point for digit_sel
//   blank        current digit is a leading zero and must be dark
//   frame_start  one-cycle pulse after digit_sel wraps 3 -> 0
//   load_ack     one-cycle pulse after pending data becomes displayed
module display_scanner #(
    parameter int DIV = 100000,
    parameter int CW  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [1:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic        dp,
    output logic        blank,
    output logic        frame_start,
    output logic        load_ack
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [15:0]   data_disp;
    logic [3:0]    dp_disp;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic          pend;

    logic tick;
    logic wrap;
    logic swap;
    logic upper_zero;

    assign tick = en && (cnt == CNT_LAST);
    assign wrap = tick && (digit_sel == 2'd3);
    // The display is static while disabled, so a pending value can go
    // straight to the display without tearing a frame.
    assign swap = pend && (wrap || !en);

    // NOTE: all state updates use non-blocking assignments. Every right-hand
    // side then reads the pre-edge value. This is what makes a load and a
    // swap on the same edge move the older pending value to the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            digit_sel   <= 2'd0;
            data_disp   <= '0;
            dp_disp     <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend        <= 1'b0;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                digit_sel <= digit_sel + 2'd1;  // natural 2-bit wrap 3 -> 0
            end

            if (swap) begin
                data_disp <= pend_data;
                dp_disp   <= pend_dp;
            end

            // A load wins over the clear from a swap on the same edge. The
            // freshly captured value then waits for the next boundary.
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pend      <= 1'b1;
            end else if (swap) begin
                pend      <= 1'b0;
            end

            frame_start <= wrap;
            load_ack    <= swap;
        end
    end

    assign nibble = data_disp[4*digit_sel +: 4];
    assign dp     = dp_disp[digit_sel];

    // A digit is a leading zero when it and every digit to its left are zero.
    // NOTE: upper_zero gets a default before the loop, so no latch is inferred.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(digit_sel) && data_disp[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blank = blank_lz && (digit_sel != 2'd0) && upper_zero;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    localparam int DIV   = 4;
    localparam int CW    = 3;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [1:0]  digit_sel;
    logic [3:0]  nibble;
    logic        dp;
    logic        blank;
    logic        frame_start;
    logic        load_ack;

    int n_checks = 0;
    int n_pass   = 0;

    display_scanner #(.DIV(DIV), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .digit_sel   (digit_sel),
        .nibble      (nibble),
        .dp          (dp),
        .blank       (blank),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {digit_sel, nibble, dp, blank, frame_start, load_ack}.
    wire [9:0] obs = {digit_sel, nibble, dp, blank, frame_start, load_ack};

    // Reference model. The digit position comes from the count of enabled
    // edges since reset, and the display contents come from a two-slot
    // (pending / displayed) view of the loads.
    int          m_edges;
    logic [15:0] m_disp, m_pdata;
    logic [3:0]  m_ddp, m_pdp;
    bit          m_pend, m_fs, m_ack;

    function automatic void model_reset();
        m_edges = 0;
        m_disp = '0; m_pdata = '0; m_ddp = '0; m_pdp = '0;
        m_pend = 0; m_fs = 0; m_ack = 0;
    endfunction

    function automatic int m_digit();
        return (m_edges / DIV) % 4;
    endfunction

    function automatic logic [9:0] exp_out();
        int          d;
        logic [15:0] upper;
        logic        b;
        d     = m_digit();
        upper = m_disp >> (4 * d);
        b     = blank_lz && (d != 0) && (upper == 16'h0);
        return {d[1:0], upper[3:0], m_ddp[d], b, m_fs, m_ack};
    endfunction

    // True when the coming edge is the last one of a frame.
    function automatic bit next_is_wrap();
        return ((m_edges + 1) % FRAME) == 0;
    endfunction

    // Advance one clock edge. The model is updated with the inputs that were
    // present at the edge, and the task returns 1 time unit later.
    task automatic step();
        bit wrap, swap;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            wrap = en && next_is_wrap();
            swap = m_pend && (wrap || !en);
            if (swap) begin
                m_disp = m_pdata;
                m_ddp  = m_pdp;
            end
            if (load) begin
                m_pdata = data_in;
                m_pdp   = dp_in;
                m_pend  = 1;
            end else if (swap) begin
                m_pend = 0;
            end
            m_fs  = wrap;
            m_ack = swap;
            if (en) m_edges++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 10'h0) $display("FAIL reset_async got=%h want=000", obs);
        else n_pass++;
        repeat (3) begin
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL reset_hold got=%h want=%h", obs, exp_out());
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int fs_seen;
        fs_seen = 0;
        en = 1'b1;
        repeat (3 * FRAME) begin
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL scan t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
            if (frame_start === 1'b1) fs_seen++;
        end
        // 48 enabled edges from reset means exactly three frame boundaries.
        n_checks++;
        if (fs_seen !== 3) $display("FAIL scan_frame_count got=%0d want=3", fs_seen);
        else n_pass++;
    endtask

    task automatic test_data_mapping();
        en = 1'b0;
        data_in = 16'h1234;
        dp_in = 4'b0100;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (load_ack !== 1'b1) $display("FAIL map_ack got=%b want=1", load_ack);
        else n_pass++;
        en = 1'b1;
        repeat (FRAME + 2) begin
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL map t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
        end
    endtask

    task automatic test_frame_swap();
        int budget;
        budget = 0;
        en = 1'b1;
        while (m_digit() != 1 && budget < 2 * FRAME) begin
            step();
            budget++;
        end
        n_checks++;
        if (m_digit() != 1) $display("FAIL swap_wait_timeout got=%0d want=1", m_digit());
        else n_pass++;
        data_in = 16'hABCD;
        dp_in = 4'b0001;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (FRAME + 4) begin
            n_checks++;
            if (obs !== exp_out()) $display("FAIL frame_swap t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
            if (frame_start === 1'b1) begin
                n_checks++;
                if (load_ack !== 1'b1 || nibble !== 4'hD)
                    $display("FAIL swap_at_frame got ack=%b nib=%h want ack=1 nib=d", load_ack, nibble);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_overwrite();
        int acks;
        acks = 0;
        en = 1'b1;
        // Start right after a boundary so that both loads land in one frame.
        while (!m_fs) step();
        data_in = 16'h1111; load = 1'b1; step();
        load = 1'b0; step();
        data_in = 16'h2222; load = 1'b1; step();
        load = 1'b0;
        repeat (2 * FRAME) begin
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL overwrite t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
            if (load_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks !== 1) $display("FAIL overwrite_ack_count got=%0d want=1", acks);
        else n_pass++;
    endtask

    task automatic test_collision();
        en = 1'b1;
        data_in = 16'h5A5A; load = 1'b1; step();
        load = 1'b0;
        while (!next_is_wrap()) step();
        data_in = 16'h6B6B; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (nibble !== 4'hA || load_ack !== 1'b1)
            $display("FAIL collision_first got nib=%h ack=%b want nib=a ack=1", nibble, load_ack);
        else n_pass++;
        repeat (FRAME + 2) begin
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL collision t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
        end
        n_checks++;
        if (m_disp !== 16'h6B6B || dut.data_disp !== 16'h6B6B)
            $display("FAIL collision_second got=%h want=6b6b", dut.data_disp);
        else n_pass++;
    endtask

    task automatic test_blank();
        logic [15:0] pats [3];
        pats[0] = 16'h0050; pats[1] = 16'h0000; pats[2] = 16'h0050;
        for (int p = 0; p < 3; p++) begin
            en = 1'b0;
            blank_lz = (p != 2);
            data_in = pats[p]; dp_in = 4'b1010; load = 1'b1;
            step();
            load = 1'b0;
            step();
            en = 1'b1;
            repeat (FRAME) begin
                step();
                n_checks++;
                if (obs !== exp_out())
                    $display("FAIL blank p=%0d t=%0t got=%h want=%h", p, $time, obs, exp_out());
                else n_pass++;
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_random();
        repeat (400) begin
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 9) == 0);
            blank_lz = $urandom_range(0, 1);
            data_in  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            dp_in    = 4'($urandom);
            step();
            n_checks++;
            if (obs !== exp_out()) $display("FAIL random t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
        end
        load = 1'b0;
        en   = 1'b1;
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        en = 1'b1;
        while (m_digit() != 2 && budget < 2 * FRAME) begin
            step();
            budget++;
        end
        data_in = 16'h9876; dp_in = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (m_digit() != 2 || !m_pend) $display("FAIL areset_setup got=%0d want=2", m_digit());
        else n_pass++;
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 10'h0) $display("FAIL areset_immediate got=%h want=000", obs);
        else n_pass++;
        step();
        rst = 1'b0;
        repeat (2 * FRAME) begin
            step();
            n_checks++;
            if (load_ack !== 1'b0 || nibble !== 4'h0 || obs !== exp_out())
                $display("FAIL areset_after t=%0t got=%h want=%h", $time, obs, exp_out());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_data_mapping();
        test_frame_swap();
        test_overwrite();
        test_collision();
        test_blank();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net: a runaway loop must still end the run.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
